fft_agu_r2: RTL and testbench
=============================

Name: fft_agu_r2

Overview:
- In-place radix-2 DIT butterfly address generator for the FFT core.
- It is the consumer end of the stage-count interface: it sequences every stage and every butterfly within it. For each butterfly it emits the two data-RAM addresses and the twiddle index.
- Input data is already in bit-reversed order in RAM. The butterfly datapath accepts one butterfly per cycle via a valid/ready handshake.

Parameters:
- LOG2N, 5, log2 of FFT size. N = 2^LOG2N. Legal range 2..7.
- STAGE_GAP, 2, idle cycles inserted between stages so the butterfly pipeline drains (avoids read-after-write hazards). Legal range 0..15.

Ports:
- clk  in  1  clock; all logic on rising edge.
- sclr  in  1  synchronous active-high reset; clears all state.
- start  in  1  single-cycle request to begin a full FFT; sampled in IDLE only.
- ready  in  1  butterfly datapath can accept the current butterfly.
- valid  out  1  addr_a/addr_b/tw_idx/stage hold a butterfly.
- addr_a  out  LOG2N  upper-leg RAM address.
- addr_b  out  LOG2N  lower-leg RAM address (addr_a + 2^stage).
- tw_idx  out  LOG2N-1  twiddle ROM index, W_N^tw_idx.
- stage  out  3  current stage index, 0..LOG2N-1.
- last_bf  out  1  current butterfly is the last (index N/2-1) of its stage; qualified by valid.
- busy  out  1  high in RUN and GAP.
- done  out  1  one-cycle pulse after the final butterfly handshake.

Behaviour:
- All outputs are registered.
- After sclr: state IDLE, all outputs 0.
- sclr has priority over every other input, including mid-operation. The in-flight FFT is abandoned with no done pulse.
- Internal counters:
  - stage counter s, 0..LOG2N-1.
  - butterfly counter j, LOG2N-1 bits, 0..N/2-1.
  - gap counter g, 4 bits.
- Address math, all unsigned with no overflow at legal parameters. With h = 2^s:
  - grp = j >> s
  - pos = j & (h-1)
  - addr_a = grp*2h + pos
  - addr_b = addr_a + h
  - tw_idx = pos << (LOG2N-1-s)
- Handshake rules:
  - A butterfly transfers on any edge where valid & ready.
  - Outputs hold stable while valid & !ready.
  - valid never drops without a transfer except on sclr.
- States and transitions:
  - IDLE: valid=0, busy=0. On start: s=0, j=0, go to RUN. valid rises in the cycle after the start edge. start outside IDLE is ignored, including during the done cycle.
  - RUN: valid=1, busy=1. On transfer with j<N/2-1: j increments, and the next butterfly appears the next cycle (one per cycle at full throughput). On transfer with j=N/2-1 (last_bf):
    - If s<LOG2N-1 and STAGE_GAP>0: go to GAP with g=STAGE_GAP, valid=0.
    - If s<LOG2N-1 and STAGE_GAP=0: stay in RUN with s+1, j=0, no bubble.
    - If s=LOG2N-1: go to DONE.
  - GAP: valid=0, busy=1. g decrements each cycle. When g reaches 1, the next state is RUN with s incremented and j=0. A gap lasts exactly STAGE_GAP cycles with valid low.
  - DONE: done=1, busy=0, valid=0 for exactly one cycle, then IDLE.
- Throughput:
  - Total transfers per FFT = LOG2N*N/2.
  - With ready held high, the cycle count from the first valid cycle to the last valid cycle inclusive is LOG2N*N/2 + (LOG2N-1)*STAGE_GAP.
- ready is ignored outside RUN.
- last_bf is 0 whenever valid=0.

Test Plan:
- sclr held 3 cycles, then released -> all outputs 0, state IDLE; ready toggling causes no change.
- Defaults, start pulse, ready=1 -> first valid cycle shows stage0 j=0: a=0, b=1, tw=0. Next cycle a=2, b=3, tw=0. Stage 2 j=5: a=9, b=13, tw=4. Stage 4 j=15: a=15, b=31, tw=15, last_bf=1. Exactly 80 transfers and 8 gap cycles (valid=0) between stages. done pulses once on the cycle after the 80th transfer.
- Random ready backpressure (~50%) -> address sequence identical to the previous scenario; outputs never change while valid & !ready; still exactly 80 transfers and one done.
- STAGE_GAP=0, LOG2N=3 -> 12 back-to-back transfers. Stage1 j=1: a=1, b=3, tw=2. Stage2 j=3: a=3, b=7, tw=3. No valid bubbles.
- sclr asserted during stage 2 with valid high, ready=0 -> next cycle all outputs 0, no done pulse. A new start then restarts at stage0 j=0.
- start asserted during RUN and during the done cycle -> ignored; no restart or corruption. start and sclr in the same cycle -> remains IDLE.

Source files
------------

// File: rtl/fft_agu_r2.sv
// fft_agu_r2: in-place radix-2 DIT butterfly address generator.
// Walks every stage s and every butterfly j of an N = 2^LOG2N point FFT.
// For each butterfly it presents the two data-RAM addresses and the twiddle
// index on a valid/ready handshake. The data is assumed to be stored in
// bit-reversed order already. STAGE_GAP idle cycles between stages let the
// butterfly pipeline drain.
//
// Ports:
//   clk      in   clock, rising edge
//   sclr     in   synchronous active-high clear, highest priority
//   start    in   one-cycle request to begin a full FFT (honoured in IDLE only)
//   ready    in   datapath accepts the current butterfly
//   valid    out  addr_a/addr_b/tw_idx/stage/last_bf hold a butterfly
//   addr_a   out  upper-leg RAM address
//   addr_b   out  lower-leg RAM address (addr_a + 2^stage)
//   tw_idx   out  twiddle ROM index
//   stage    out  current stage index
//   last_bf  out  current butterfly is the last one of its stage
//   busy     out  high while running or in an inter-stage gap
//   done     out  one-cycle pulse after the final butterfly transfer
module fft_agu_r2 #(
    parameter int unsigned LOG2N     = 5,
    parameter int unsigned STAGE_GAP = 2
) (
    input  logic             clk,
    input  logic             sclr,
    input  logic             start,
    input  logic             ready,
    output logic             valid,
    output logic [LOG2N-1:0] addr_a,
    output logic [LOG2N-1:0] addr_b,
    output logic [LOG2N-2:0] tw_idx,
    output logic [2:0]       stage,
    output logic             last_bf,
    output logic             busy,
    output logic             done
);

    localparam int unsigned JW = LOG2N - 1;
    localparam logic [JW-1:0] JLast   = '1;  // N/2-1
    localparam logic [2:0]    SLast   = 3'(LOG2N - 1);
    localparam logic [3:0]    GapInit = 4'(STAGE_GAP);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StGap,
        StDone
    } state_e;

    state_e        state_q, state_d;
    logic [2:0]    s_q, s_d;
    logic [JW-1:0] j_q, j_d;
    logic [3:0]    g_q, g_d;

    logic             valid_q, valid_d;
    logic [LOG2N-1:0] addr_a_q, addr_a_d;
    logic [LOG2N-1:0] addr_b_q, addr_b_d;
    logic [LOG2N-2:0] tw_idx_q, tw_idx_d;
    logic [2:0]       stage_q, stage_d;
    logic             last_bf_q, last_bf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Next-state sequencing of stage / butterfly / gap counters.
    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        j_d     = j_q;
        g_d     = g_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRun;
                    s_d     = '0;
                    j_d     = '0;
                end
            end
            StRun: begin
                if (ready) begin
                    if (j_q != JLast) begin
                        j_d = j_q + JW'(1);
                    end else if (s_q != SLast) begin
                        if (STAGE_GAP > 0) begin
                            state_d = StGap;
                            g_d     = GapInit;
                        end else begin
                            s_d = s_q + 3'd1;
                            j_d = '0;
                        end
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StGap: begin
                g_d = g_q - 4'd1;
                if (g_q == 4'd1) begin
                    state_d = StRun;
                    s_d     = s_q + 3'd1;
                    j_d     = '0;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Address math on the next-state counters so every output is a flop.
    logic [LOG2N-1:0] j_ext, h, grp, pos, a_calc;

    always_comb begin
        j_ext  = {1'b0, j_d};
        h      = LOG2N'(1) << s_d;
        grp    = j_ext >> s_d;
        pos    = j_ext & (h - LOG2N'(1));
        a_calc = ((grp << s_d) << 1) + pos;

        valid_d   = (state_d == StRun);
        busy_d    = (state_d == StRun) || (state_d == StGap);
        done_d    = (state_d == StDone);
        addr_a_d  = '0;
        addr_b_d  = '0;
        tw_idx_d  = '0;
        stage_d   = '0;
        last_bf_d = 1'b0;
        if (valid_d) begin
            addr_a_d  = a_calc;
            addr_b_d  = a_calc + h;
            // pos < 2^s <= N/2, so it fits the twiddle width before shifting.
            tw_idx_d  = pos[LOG2N-2:0] << (SLast - s_d);
            stage_d   = s_d;
            last_bf_d = (j_d == JLast);
        end
    end

    always_ff @(posedge clk) begin
        if (sclr) begin
            state_q   <= StIdle;
            s_q       <= '0;
            j_q       <= '0;
            g_q       <= '0;
            valid_q   <= 1'b0;
            addr_a_q  <= '0;
            addr_b_q  <= '0;
            tw_idx_q  <= '0;
            stage_q   <= '0;
            last_bf_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_q       <= s_d;
            j_q       <= j_d;
            g_q       <= g_d;
            valid_q   <= valid_d;
            addr_a_q  <= addr_a_d;
            addr_b_q  <= addr_b_d;
            tw_idx_q  <= tw_idx_d;
            stage_q   <= stage_d;
            last_bf_q <= last_bf_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign valid   = valid_q;
    assign addr_a  = addr_a_q;
    assign addr_b  = addr_b_q;
    assign tw_idx  = tw_idx_q;
    assign stage   = stage_q;
    assign last_bf = last_bf_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_fft_agu_r2.sv
// Self-checking bench for fft_agu_r2: a default instance (LOG2N=5, STAGE_GAP=2)
// and a small instance (LOG2N=3, STAGE_GAP=0), selected through a shared mux.
module tb_fft_agu_r2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic sclr, start_r, ready_r, sel;
    logic start0, ready0, start1, ready1;

    assign start0 = !sel && start_r;
    assign ready0 = !sel && ready_r;
    assign start1 = sel && start_r;
    assign ready1 = sel && ready_r;

    logic       valid0, last0, busy0, done0;
    logic [4:0] addr_a0, addr_b0;
    logic [3:0] tw0;
    logic [2:0] stage0;

    logic       valid1, last1, busy1, done1;
    logic [2:0] addr_a1, addr_b1;
    logic [1:0] tw1;
    logic [2:0] stage1;

    fft_agu_r2 #(.LOG2N(5), .STAGE_GAP(2)) u_dut0 (
        .clk(clk), .sclr(sclr), .start(start0), .ready(ready0),
        .valid(valid0), .addr_a(addr_a0), .addr_b(addr_b0), .tw_idx(tw0),
        .stage(stage0), .last_bf(last0), .busy(busy0), .done(done0)
    );

    fft_agu_r2 #(.LOG2N(3), .STAGE_GAP(0)) u_dut1 (
        .clk(clk), .sclr(sclr), .start(start1), .ready(ready1),
        .valid(valid1), .addr_a(addr_a1), .addr_b(addr_b1), .tw_idx(tw1),
        .stage(stage1), .last_bf(last1), .busy(busy1), .done(done1)
    );

    logic       m_valid, m_last, m_busy, m_done;
    logic [7:0] m_a, m_b, m_tw;
    logic [2:0] m_st;
    logic [28:0] snap_now;

    always_comb begin
        if (sel) begin
            m_valid = valid1; m_last = last1; m_busy = busy1; m_done = done1;
            m_a = 8'(addr_a1); m_b = 8'(addr_b1); m_tw = 8'(tw1); m_st = stage1;
        end else begin
            m_valid = valid0; m_last = last0; m_busy = busy0; m_done = done0;
            m_a = 8'(addr_a0); m_b = 8'(addr_b0); m_tw = 8'(tw0); m_st = stage0;
        end
    end
    assign snap_now = {m_valid, m_last, m_st, m_a, m_b, m_tw};

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference sequence from the textbook nested loop over groups and positions.
    int exp_a [0:79];
    int exp_b [0:79];
    int exp_tw[0:79];
    int exp_st[0:79];
    int exp_lb[0:79];

    task automatic build_model(input int lg);
        int n, k, h, ngrp;
        n = 1 << lg;
        k = 0;
        for (int s = 0; s < lg; s++) begin
            h    = 1 << s;
            ngrp = n / (2 * h);
            for (int grp = 0; grp < ngrp; grp++) begin
                for (int pos = 0; pos < h; pos++) begin
                    exp_a[k]  = grp * 2 * h + pos;
                    exp_b[k]  = grp * 2 * h + pos + h;
                    exp_tw[k] = pos * ngrp;
                    exp_st[k] = s;
                    exp_lb[k] = (grp == ngrp - 1 && pos == h - 1) ? 1 : 0;
                    k++;
                end
            end
        end
    endtask

    task automatic run_fft(input int lg, input int sg, input bit bp, input bit poke,
                           input string tag);
        int total, cyc, nx, ndone, first, last, lastx, gaps;
        bit prev_stall, bad;
        logic [28:0] snap_prev;
        total = lg * (1 << (lg - 1));
        cyc = 0; nx = 0; ndone = 0; first = -1; last = -1; lastx = -1; gaps = 0;
        prev_stall = 1'b0;
        snap_prev  = '0;
        build_model(lg);
        start_r = 1'b1;
        ready_r = 1'b1;
        tick();
        start_r = 1'b0;
        while (ndone == 0 && cyc < 4000) begin
            ready_r = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
            start_r = poke && (cyc == 10);
            if (prev_stall) check_val({tag, ".hold"}, 32'(snap_now), 32'(snap_prev));
            if (m_valid) begin
                if (first < 0) first = cyc;
                last = cyc;
            end else if (first >= 0 && !m_done) begin
                gaps++;
            end
            if (m_valid && ready_r) begin
                if (nx < total) begin
                    check_val({tag, ".a"},  32'(m_a),  exp_a[nx]);
                    check_val({tag, ".b"},  32'(m_b),  exp_b[nx]);
                    check_val({tag, ".tw"}, 32'(m_tw), exp_tw[nx]);
                    check_val({tag, ".st"}, 32'(m_st), exp_st[nx]);
                    check_val({tag, ".lb"}, 32'(m_last), exp_lb[nx]);
                end
                // Hand-computed anchor vectors: {a, b, tw, last}.
                if (lg == 5 && nx == 0)  check_val({tag, ".v0"},  {m_a, m_b, m_tw, 7'd0, m_last}, {8'd0, 8'd1, 8'd0, 8'd0});
                if (lg == 5 && nx == 1)  check_val({tag, ".v1"},  {m_a, m_b, m_tw, 7'd0, m_last}, {8'd2, 8'd3, 8'd0, 8'd0});
                if (lg == 5 && nx == 37) check_val({tag, ".s2j5"}, {m_a, m_b, m_tw, 7'd0, m_last}, {8'd9, 8'd13, 8'd4, 8'd0});
                if (lg == 5 && nx == 79) check_val({tag, ".s4j15"}, {m_a, m_b, m_tw, 7'd0, m_last}, {8'd15, 8'd31, 8'd15, 8'd1});
                if (lg == 3 && nx == 5)  check_val({tag, ".s1j1"}, {m_a, m_b, m_tw, 7'd0, m_last}, {8'd1, 8'd3, 8'd2, 8'd0});
                if (lg == 3 && nx == 11) check_val({tag, ".s2j3"}, {m_a, m_b, m_tw, 7'd0, m_last}, {8'd3, 8'd7, 8'd3, 8'd1});
                lastx = cyc;
                nx++;
            end
            if (m_done) begin
                ndone++;
                check_val({tag, ".done_at"}, 32'(cyc), 32'(lastx + 1));
                check_val({tag, ".done_busy"}, 32'(m_busy), 32'd0);
                if (poke) start_r = 1'b1;
            end
            prev_stall = m_valid && !ready_r;
            snap_prev  = snap_now;
            tick();
            cyc++;
        end
        start_r = 1'b0;
        ready_r = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bad = bad | m_valid | m_done | m_busy;
            tick();
        end
        check_val({tag, ".quiet"}, 32'(bad), 32'd0);
        check_val({tag, ".first"}, 32'(first), 32'd0);
        check_val({tag, ".nxfer"}, 32'(nx), 32'(total));
        check_val({tag, ".ndone"}, 32'(ndone), 32'd1);
        check_val({tag, ".gaps"}, 32'(gaps), 32'((lg - 1) * sg));
        if (!bp) check_val({tag, ".span"}, 32'(last - first + 1), 32'(total + (lg - 1) * sg));
    endtask

    initial begin
        int wait_cyc;
        bit bad;
        sclr = 1'b1; start_r = 1'b0; ready_r = 1'b0; sel = 1'b0;
        tick(); tick(); tick();
        sclr = 1'b0;
        check_val("rst0", {valid0, last0, busy0, done0, stage0, addr_a0, addr_b0, tw0}, 32'd0);
        check_val("rst1", {valid1, last1, busy1, done1, stage1, addr_a1, addr_b1, tw1}, 32'd0);
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ready_r = ~ready_r;
            tick();
            bad = bad | valid0 | busy0 | done0;
        end
        check_val("idle_ready", 32'(bad), 32'd0);

        // Full run with stray start pulses during RUN and in the done cycle.
        run_fft(5, 2, 1'b0, 1'b1, "full");
        run_fft(5, 2, 1'b1, 1'b0, "bp");

        sel = 1'b1;
        #1;
        run_fft(3, 0, 1'b0, 1'b0, "g0");
        sel = 1'b0;
        #1;

        // Abort in stage 2 while stalled.
        start_r = 1'b1; ready_r = 1'b1;
        tick();
        start_r = 1'b0;
        wait_cyc = 0;
        while (!(valid0 && stage0 == 3'd2) && wait_cyc < 200) begin
            tick();
            wait_cyc++;
        end
        check_val("abort_reach", 32'(valid0 && stage0 == 3'd2), 32'd1);
        ready_r = 1'b0;
        tick(); tick();
        check_val("abort_stall", {29'd0, valid0, stage0 == 3'd2, busy0}, 32'd7);
        sclr = 1'b1;
        tick();
        sclr = 1'b0;
        check_val("abort_clr", {valid0, last0, busy0, done0, stage0, addr_a0, addr_b0, tw0}, 32'd0);
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            bad = bad | valid0 | done0 | busy0;
        end
        check_val("abort_nodone", 32'(bad), 32'd0);

        run_fft(5, 2, 1'b0, 1'b0, "restart");

        // start coinciding with sclr must leave the block idle.
        sclr = 1'b1; start_r = 1'b1;
        tick();
        sclr = 1'b0; start_r = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            bad = bad | valid0 | busy0 | done0;
        end
        check_val("sclr_start", 32'(bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
